uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Parametrised successor to the UART calculator front-end decoder. Consumes the byte stream from the UART RX block and parses frames of the form "I<sp>T<sp>H1..Hn<op>H1..Hn=".
- Variable-length hex operands of DATA_W bits.
- Explicit error detection and recovery.
- Valid/ready handshake toward the ALU stage.
Sits between uart_rx and the calculator core.

Parameters:
DATA_W, 16, operand width in bits; must be a multiple of 4, range 8..64
MAX_DIG, DATA_W/4, maximum hex digits accepted per operand (derived; do not override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx_data  input  8  received ASCII byte
rx_valid  input  1  one-cycle strobe, rx_data valid
cmd_valid  output  1  parsed command available
cmd_ready  input  1  downstream accepts command
dtype  output  2  1=signed('S'), 2=unsigned('U'), 0=none
operator  output  3  0 '+', 1 '-', 2 '*', 3 '/'
src1  output  DATA_W  operand 1, right-aligned, zero-extended
src2  output  DATA_W  operand 2, right-aligned, zero-extended
err_valid  output  1  one-cycle pulse on error detection
err_code  output  3  1 FMT, 2 TYPE, 3 CHAR, 4 EMPTY, 5 OVF, 6 OVERRUN; holds last code

Behaviour:
- Reset: state IDLE; cmd_valid=0, err_valid=0, err_code=0, dtype=0, operator=0, src1=src2=0, digit counter=0. Reset mid-frame discards the partial frame.
- States advance only on rx_valid=1; with rx_valid=0 every register holds.
- IDLE: 'I'(0x49) -> SP1; any other byte -> ERR FMT.
- SP1: 0x20 -> TYPE; else ERR CHAR.
- TYPE: 'S'(0x53) -> dtype_next=1; 'U'(0x55) -> dtype_next=2; go SP2. Else ERR TYPE.
- SP2: 0x20 -> OPD1; clear src1 accumulator and digit count. Else ERR CHAR.
- OPD1, hex digit ('0'-'9', 'A'-'F'): src1 <= {src1[DATA_W-5:0], nibble}, cnt+1. A digit arriving with cnt==MAX_DIG -> ERR OVF.
- OPD1, operator ('+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F): with cnt==0 -> ERR EMPTY; else latch operator, clear cnt and src2, go OPD2.
- OPD1, any other byte -> ERR CHAR.
- OPD2: same digit and overflow rules, applied to src2. '=' (0x3D): cnt==0 -> ERR EMPTY; else go HOLD.
- HOLD: cmd_valid=1 starting the cycle after '=' is sampled (1-cycle latency). dtype, operator, src1 and src2 are stable for the whole of HOLD.
- HOLD exit: cmd_valid&&cmd_ready -> IDLE next cycle.
- HOLD with rx_valid=1 and cmd_ready=0: byte dropped, err_valid pulse with code OVERRUN, stay in HOLD.
- HOLD with rx_valid=1 and cmd_ready=1 in the same cycle: handshake completes and the byte is processed as the first byte of the next frame (IDLE rules).
- ERR entry: err_valid pulses for exactly one cycle and err_code updates; state goes FLUSH. If the offending byte itself is '=', go straight to IDLE.
- FLUSH: discard bytes until '=' -> IDLE. Never asserts cmd_valid; no further err_valid pulses.
- dtype and operator outputs update only on entry to HOLD; outside HOLD they retain the last accepted command. src1/src2 are the live accumulators.
- Registered outputs; no combinational path from rx_data to any output.

Optional Feature:
LOWERCASE_HEX_EN
- Defined: 'a'-'f' (0x61-0x66) are accepted as digits 10-15 and 's'/'u' are accepted in TYPE.
- Undefined: these bytes give ERR CHAR (digits) or ERR TYPE (type field).

Decomposition:
- Package uart_calc_pkg:
  - state enum (IDLE, SP1, TYPE, SP2, OPD1, OPD2, HOLD, FLUSH)
  - ASCII constants (SPACE, EQ, I, S, U, operator characters)
  - operator codes, dtype codes, err_code values
- One sub-module: hex_ascii_decode. Combinational; byte -> {is_hex, nibble[3:0]}. Honours LOWERCASE_HEX_EN.

Test Plan:
1. DATA_W=16; bytes "I S 12AB+0F=", cmd_ready=1 -> cmd_valid for 1 cycle, one cycle after '='; dtype=1, operator=0, src1=0x12AB, src2=0x000F.
2. "I U 1-2=" with cmd_ready=0 for 5 cycles, then an extra byte 'X' during HOLD -> cmd_valid held 5+ cycles, outputs stable; err_valid pulse with err_code=6; command still delivered when ready=1.
3. "I S 12345+1=" -> err_valid on the 5th digit, err_code=5, no cmd_valid; the next frame "I U F/3=" parses: src1=0xF, src2=0x3, operator=3.
4. "I S +5=" -> err_code=4 (EMPTY); "I Q 1+1=" -> err_code=2; "Z" in IDLE -> err_code=1. Each case flushes to '=' and recovers.
5. rst asserted after "I S 12" -> next cycle all outputs zero; a following full frame parses correctly.
6. LOWERCASE_HEX_EN defined: "I u ab*c=" -> src1=0xAB, src2=0xC, operator=2, dtype=2. Undefined: same bytes -> err_code=2 at 'u'.

Source files
------------

// File: rtl/uart_calc_pkg.sv
// Shared types and constants for the UART calculator command front end:
// parser states, ASCII bytes of the frame grammar, operator/dtype/error codes.
// LOWERCASE_HEX_EN adds the lowercase type characters used by the parser.
package uart_calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SP1   = 3'd1,
    ST_TYPE  = 3'd2,
    ST_SP2   = 3'd3,
    ST_OPD1  = 3'd4,
    ST_OPD2  = 3'd5,
    ST_HOLD  = 3'd6,
    ST_FLUSH = 3'd7
  } state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_U     = 8'h55;
  localparam logic [7:0] CH_LS    = 8'h73;
  localparam logic [7:0] CH_LU    = 8'h75;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam logic [1:0] DT_NONE     = 2'd0;
  localparam logic [1:0] DT_SIGNED   = 2'd1;
  localparam logic [1:0] DT_UNSIGNED = 2'd2;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FMT     = 3'd1;
  localparam logic [2:0] ERR_TYPE    = 3'd2;
  localparam logic [2:0] ERR_CHAR    = 3'd3;
  localparam logic [2:0] ERR_EMPTY   = 3'd4;
  localparam logic [2:0] ERR_OVF     = 3'd5;
  localparam logic [2:0] ERR_OVERRUN = 3'd6;

  // Returns {is_operator, operator_code}.
  function automatic logic [3:0] op_lookup(input logic [7:0] ch);
    case (ch)
      CH_PLUS:  return {1'b1, OP_ADD};
      CH_MINUS: return {1'b1, OP_SUB};
      CH_STAR:  return {1'b1, OP_MUL};
      CH_SLASH: return {1'b1, OP_DIV};
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input, command valid/ready output and error report of the parser.
// slave = parser side, master = byte source / command consumer side.
interface uart_cmd_parser_if #(
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        dtype;
  logic [2:0]        operator;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              err_valid;
  logic [2:0]        err_code;

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, dtype, operator, src1, src2, err_valid, err_code
  );

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, dtype, operator, src1, src2, err_valid, err_code
  );
endinterface

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: byte -> {is_hex, nibble}, zero latency.
// Uppercase only unless LOWERCASE_HEX_EN is defined.
module hex_ascii_decode (
  input  logic [7:0] data_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'd0;
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      is_hex_o = 1'b1;
      nibble_o = data_i[3:0];
    end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
      // 'A'..'F' have low nibble 1..6
      is_hex_o = 1'b1;
      nibble_o = data_i[3:0] + 4'd9;
    end
`ifdef LOWERCASE_HEX_EN
    else if (data_i >= 8'h61 && data_i <= 8'h66) begin
      is_hex_o = 1'b1;
      nibble_o = data_i[3:0] + 4'd9;
    end
`endif
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "I T Hx..Hx<op>Hx..Hx=" frames from uart_rx into a held command; cmd_valid 1 cycle after '='.
// Holds the command until cmd_ready; bytes arriving while held are dropped with OVERRUN. Macro: LOWERCASE_HEX_EN.
module uart_cmd_parser
  import uart_calc_pkg::*;
#(
  parameter  int DATA_W  = 16,
  localparam int MAX_DIG = DATA_W / 4,
  localparam int CNT_W   = $clog2(MAX_DIG + 1)
) (
  input logic clk,
  input logic rst,
  uart_cmd_parser_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIG);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        dtype_q, dtype_d, dtype_pend_q, dtype_pend_d;
  logic [2:0]        op_q, op_d, op_pend_q, op_pend_d;
  logic              err_valid_q, err_valid_d;
  logic [2:0]        err_code_q, err_code_d;

  logic       is_hex;
  logic [3:0] nibble;
  logic       is_op;
  logic [2:0] op_code;
  logic       type_s, type_u;
  logic       is_eq;
  logic       hold_ack;
  state_e     cur_state;
  logic       raise_err;
  logic [2:0] err_sel;

  hex_ascii_decode u_hex (
    .data_i   (bus.rx_data),
    .is_hex_o (is_hex),
    .nibble_o (nibble)
  );

  assign {is_op, op_code} = op_lookup(bus.rx_data);
  assign is_eq = (bus.rx_data == CH_EQ);

`ifdef LOWERCASE_HEX_EN
  assign type_s = (bus.rx_data == CH_S) || (bus.rx_data == CH_LS);
  assign type_u = (bus.rx_data == CH_U) || (bus.rx_data == CH_LU);
`else
  assign type_s = (bus.rx_data == CH_S);
  assign type_u = (bus.rx_data == CH_U);
`endif

  assign hold_ack = (state_q == ST_HOLD) && bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      src1_q       <= '0;
      src2_q       <= '0;
      cnt_q        <= '0;
      dtype_q      <= DT_NONE;
      dtype_pend_q <= DT_NONE;
      op_q         <= OP_ADD;
      op_pend_q    <= OP_ADD;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      cnt_q        <= cnt_d;
      dtype_q      <= dtype_d;
      dtype_pend_q <= dtype_pend_d;
      op_q         <= op_d;
      op_pend_q    <= op_pend_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    cnt_d        = cnt_q;
    dtype_d      = dtype_q;
    dtype_pend_d = dtype_pend_q;
    op_d         = op_q;
    op_pend_d    = op_pend_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    raise_err    = 1'b0;
    err_sel      = ERR_NONE;

    // A handshake frees HOLD this cycle, so a coincident byte starts the next frame.
    cur_state = hold_ack ? ST_IDLE : state_q;
    if (hold_ack) state_d = ST_IDLE;

    if (bus.rx_valid) begin
      case (cur_state)
        ST_IDLE: begin
          if (bus.rx_data == CH_I) state_d = ST_SP1;
          else begin raise_err = 1'b1; err_sel = ERR_FMT; end
        end
        ST_SP1: begin
          if (bus.rx_data == CH_SPACE) state_d = ST_TYPE;
          else begin raise_err = 1'b1; err_sel = ERR_CHAR; end
        end
        ST_TYPE: begin
          if (type_s) begin
            dtype_pend_d = DT_SIGNED;
            state_d      = ST_SP2;
          end else if (type_u) begin
            dtype_pend_d = DT_UNSIGNED;
            state_d      = ST_SP2;
          end else begin
            raise_err = 1'b1;
            err_sel   = ERR_TYPE;
          end
        end
        ST_SP2: begin
          if (bus.rx_data == CH_SPACE) begin
            src1_d  = '0;
            cnt_d   = CNT_ZERO;
            state_d = ST_OPD1;
          end else begin
            raise_err = 1'b1;
            err_sel   = ERR_CHAR;
          end
        end
        ST_OPD1: begin
          if (is_hex) begin
            if (cnt_q == CNT_MAX) begin raise_err = 1'b1; err_sel = ERR_OVF; end
            else begin
              src1_d = {src1_q[DATA_W-5:0], nibble};
              cnt_d  = cnt_q + CNT_ONE;
            end
          end else if (is_op) begin
            if (cnt_q == CNT_ZERO) begin raise_err = 1'b1; err_sel = ERR_EMPTY; end
            else begin
              op_pend_d = op_code;
              cnt_d     = CNT_ZERO;
              src2_d    = '0;
              state_d   = ST_OPD2;
            end
          end else begin
            raise_err = 1'b1;
            err_sel   = ERR_CHAR;
          end
        end
        ST_OPD2: begin
          if (is_hex) begin
            if (cnt_q == CNT_MAX) begin raise_err = 1'b1; err_sel = ERR_OVF; end
            else begin
              src2_d = {src2_q[DATA_W-5:0], nibble};
              cnt_d  = cnt_q + CNT_ONE;
            end
          end else if (is_eq) begin
            if (cnt_q == CNT_ZERO) begin raise_err = 1'b1; err_sel = ERR_EMPTY; end
            else begin
              dtype_d = dtype_pend_q;
              op_d    = op_pend_q;
              state_d = ST_HOLD;
            end
          end else begin
            raise_err = 1'b1;
            err_sel   = ERR_CHAR;
          end
        end
        ST_HOLD: begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        ST_FLUSH: begin
          if (is_eq) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A frame that dies on its own '=' is already resynchronised.
    if (raise_err) begin
      err_valid_d = 1'b1;
      err_code_d  = err_sel;
      state_d     = is_eq ? ST_IDLE : ST_FLUSH;
    end
  end

  always_comb begin
    bus.cmd_valid = (state_q == ST_HOLD);
    bus.dtype     = dtype_q;
    bus.operator  = op_q;
    bus.src1      = src1_q;
    bus.src2      = src2_q;
    bus.err_valid = err_valid_q;
    bus.err_code  = err_code_q;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser (DATA_W=16): normal frames, backpressure/overrun,
// every error class with recovery, reset mid-frame and the LOWERCASE_HEX_EN option.
module tb_uart_cmd_parser;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_cmd_parser_if #(.DATA_W(16)) bus ();

  uart_cmd_parser #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.cmd_ready = 1'b1;
    tick();
    tick();
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_err_valid", bus.err_valid, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_dtype", bus.dtype, 0);
    check("rst_operator", bus.operator, 0);
    check("rst_src1", bus.src1, 0);
    check("rst_src2", bus.src2, 0);
    rst = 1'b0;

    // Basic frame, consumer always ready
    send_str("I S 12AB+0F=");
    check("t1_cmd_valid", bus.cmd_valid, 1);
    check("t1_dtype", bus.dtype, 1);
    check("t1_operator", bus.operator, 0);
    check("t1_src1", bus.src1, 16'h12AB);
    check("t1_src2", bus.src2, 16'h000F);
    check("t1_err_valid", bus.err_valid, 0);
    tick();
    check("t1_cmd_done", bus.cmd_valid, 0);
    check("t1_dtype_kept", bus.dtype, 1);

    // Backpressure with an overrun byte during HOLD
    bus.cmd_ready = 1'b0;
    send_str("I U 1-2=");
    check("t2_cmd_valid", bus.cmd_valid, 1);
    check("t2_dtype", bus.dtype, 2);
    check("t2_operator", bus.operator, 1);
    check("t2_src1", bus.src1, 16'h0001);
    check("t2_src2", bus.src2, 16'h0002);
    repeat (4) tick();
    check("t2_held_valid", bus.cmd_valid, 1);
    check("t2_held_src1", bus.src1, 16'h0001);
    send_byte("X");
    check("t2_ovr_pulse", bus.err_valid, 1);
    check("t2_ovr_code", bus.err_code, 6);
    check("t2_ovr_still_valid", bus.cmd_valid, 1);
    check("t2_ovr_src2", bus.src2, 16'h0002);
    check("t2_ovr_operator", bus.operator, 1);
    tick();
    check("t2_ovr_pulse_end", bus.err_valid, 0);
    check("t2_valid_before_ack", bus.cmd_valid, 1);
    bus.cmd_ready = 1'b1;
    tick();
    check("t2_acked", bus.cmd_valid, 0);

    // Byte arriving in the handshake cycle opens the next frame
    send_str("I U 1+2=");
    check("bb_first_valid", bus.cmd_valid, 1);
    send_str("I S 3*4=");
    check("bb_second_valid", bus.cmd_valid, 1);
    check("bb_no_err", bus.err_valid, 0);
    check("bb_err_code_kept", bus.err_code, 6);
    check("bb_dtype", bus.dtype, 1);
    check("bb_operator", bus.operator, 2);
    check("bb_src1", bus.src1, 16'h0003);
    check("bb_src2", bus.src2, 16'h0004);
    tick();

    // Operand overflow then recovery
    send_str("I S 1234");
    send_byte("5");
    check("t3_ovf_pulse", bus.err_valid, 1);
    check("t3_ovf_code", bus.err_code, 5);
    send_str("+1=");
    check("t3_no_cmd", bus.cmd_valid, 0);
    check("t3_no_repulse", bus.err_valid, 0);
    send_str("I U F/3=");
    check("t3_rec_valid", bus.cmd_valid, 1);
    check("t3_rec_src1", bus.src1, 16'h000F);
    check("t3_rec_src2", bus.src2, 16'h0003);
    check("t3_rec_operator", bus.operator, 3);
    check("t3_rec_dtype", bus.dtype, 2);
    check("t3_code_held", bus.err_code, 5);
    tick();

    // Exactly MAX_DIG digits is legal
    send_str("I U FFFF-0000=");
    check("max_valid", bus.cmd_valid, 1);
    check("max_src1", bus.src1, 16'hFFFF);
    check("max_src2", bus.src2, 16'h0000);
    check("max_no_err", bus.err_valid, 0);
    tick();

    // Error classes, each flushed to '='
    send_str("I S ");
    send_byte("+");
    check("t4_empty_pulse", bus.err_valid, 1);
    check("t4_empty_code", bus.err_code, 4);
    send_str("5=");
    check("t4_empty_no_cmd", bus.cmd_valid, 0);
    check("t4_dtype_kept", bus.dtype, 2);
    send_str("I ");
    send_byte("Q");
    check("t4_type_pulse", bus.err_valid, 1);
    check("t4_type_code", bus.err_code, 2);
    send_str(" 1+1=");
    check("t4_type_no_cmd", bus.cmd_valid, 0);
    send_byte("Z");
    check("t4_fmt_pulse", bus.err_valid, 1);
    check("t4_fmt_code", bus.err_code, 1);
    send_str(" 1=");
    check("t4_fmt_no_repulse", bus.err_valid, 0);
    check("t4_fmt_no_cmd", bus.cmd_valid, 0);
    send_str("I S 1+");
    send_byte("=");
    check("t4_eq_empty_pulse", bus.err_valid, 1);
    check("t4_eq_empty_code", bus.err_code, 4);
    send_str("I S A*B=");
    check("t4_rec_valid", bus.cmd_valid, 1);
    check("t4_rec_src1", bus.src1, 16'h000A);
    check("t4_rec_src2", bus.src2, 16'h000B);
    check("t4_rec_operator", bus.operator, 2);
    check("t4_rec_dtype", bus.dtype, 1);
    tick();
    send_str("I S 1");
    send_byte("=");
    check("t4_opd1_eq_code", bus.err_code, 3);
    send_str("I U 9-8=");
    check("t4_opd1_eq_rec", bus.cmd_valid, 1);
    check("t4_opd1_eq_src2", bus.src2, 16'h0008);
    tick();

    // Reset mid-frame
    send_str("I S 12");
    check("t5_partial_src1", bus.src1, 16'h0012);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_cmd_valid", bus.cmd_valid, 0);
    check("t5_err_valid", bus.err_valid, 0);
    check("t5_err_code", bus.err_code, 0);
    check("t5_dtype", bus.dtype, 0);
    check("t5_operator", bus.operator, 0);
    check("t5_src1", bus.src1, 0);
    check("t5_src2", bus.src2, 0);
    send_str("I S 7+8=");
    check("t5_rec_valid", bus.cmd_valid, 1);
    check("t5_rec_src1", bus.src1, 16'h0007);
    check("t5_rec_src2", bus.src2, 16'h0008);
    check("t5_rec_dtype", bus.dtype, 1);
    check("t5_rec_operator", bus.operator, 0);
    tick();

    // Lowercase handling
`ifdef LOWERCASE_HEX_EN
    send_str("I u ab*c=");
    check("t6_lc_valid", bus.cmd_valid, 1);
    check("t6_lc_src1", bus.src1, 16'h00AB);
    check("t6_lc_src2", bus.src2, 16'h000C);
    check("t6_lc_operator", bus.operator, 2);
    check("t6_lc_dtype", bus.dtype, 2);
    check("t6_lc_no_err", bus.err_valid, 0);
    tick();
`else
    send_str("I ");
    send_byte("u");
    check("t6_uc_type_pulse", bus.err_valid, 1);
    check("t6_uc_type_code", bus.err_code, 2);
    send_str(" ab*c=");
    check("t6_uc_no_cmd", bus.cmd_valid, 0);
    send_str("I S ");
    send_byte("a");
    check("t6_uc_char_pulse", bus.err_valid, 1);
    check("t6_uc_char_code", bus.err_code, 3);
    send_str("=");
    send_str("I U 5/5=");
    check("t6_uc_rec_valid", bus.cmd_valid, 1);
    check("t6_uc_rec_operator", bus.operator, 3);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
